switch_event_gen: RTL and testbench

- Downstream consumer of the debounced switch level (dbsw) from the debounce stage.
- Converts the level into single-cycle event pulses:
  - press
  - release
  - long_press after a hold time
  - auto-repeat while held
- Shares swclock and the swtick prescaler tick with the debouncer, so hold and repeat times are counted in debounce ticks.
- Feeds the keyboard/control logic, e.g. ZX key injection and menu stepping.

---
 rtl/switch_event_gen_pkg.sv | 27 ++
 rtl/switch_event_gen_tick_counter.sv | 34 +++
 rtl/switch_event_gen.sv | 122 ++++++++++++
 tb/tb_switch_event_gen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/switch_event_gen_pkg.sv
// Shared types for the switch event generator. Downstream debug and display logic can decode the
// raw 3-bit state output against these values.
package switch_event_gen_pkg;

    localparam int unsigned StateW = 3;

    typedef enum logic [StateW-1:0] {
        StInit    = 3'b000,
        StIdle    = 3'b001,
        StPressed = 3'b010,
        StRepeat  = 3'b011,
        StWaitRel = 3'b100
    } sw_state_e;

    // One bit per pulse type; at most one bit is ever set.
    typedef struct packed {
        logic press;
        logic release_pulse;
        logic long_press;
        logic repeat_pulse;
    } sw_events_t;

    function automatic logic state_is_held(input sw_state_e s);
        return (s == StPressed) || (s == StRepeat);
    endfunction

endpackage

// File: rtl/switch_event_gen_tick_counter.sv
// Counts enable strobes up to a terminal value; strobes hit on the terminal count and reloads to 0.
module switch_event_gen_tick_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             swclock,
    input  logic             swreset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] terminal,
    output logic             hit
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign hit = enable && (cnt_q == terminal);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = hit ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge swclock) begin
        if (swreset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/switch_event_gen.sv
// Turns the debounced switch level into press / release / long_press / repeat pulses, counting hold
// time in prescaler ticks. All outputs are registered.
module switch_event_gen
    import switch_event_gen_pkg::*;
#(
    parameter int unsigned LONG_TICKS   = 8,
    parameter int unsigned REPEAT_TICKS = 3,
    parameter int unsigned CNT_W        = 4
) (
    input  logic              swclock,
    input  logic              swreset,
    input  logic              swtick,
    input  logic              dbsw,
    output logic              press,
    // release and repeat are reserved words, hence the suffixed names.
    output logic              release_pulse,
    output logic              long_press,
    output logic              repeat_pulse,
    output logic              held,
    output logic [StateW-1:0] state
);

    localparam logic [CNT_W-1:0] LongTerm   = CNT_W'(LONG_TICKS - 1);
    localparam bit               RepeatEn   = (REPEAT_TICKS != 0);
    localparam logic [CNT_W-1:0] RepeatTerm = RepeatEn ? CNT_W'(REPEAT_TICKS - 1) : '0;

    sw_state_e        state_q, state_d;
    sw_events_t       ev_q, ev_d;
    logic             held_q, held_d;

    logic             cnt_clear;
    logic             cnt_en;
    logic             cnt_hit;
    logic [CNT_W-1:0] cnt_term;

    // The single counter is shared: it times the long hold in PRESSED, then the repeat period.
    always_comb begin
        cnt_term  = (state_q == StRepeat) ? RepeatTerm : LongTerm;
        cnt_en    = swtick && dbsw &&
                    ((state_q == StPressed) || ((state_q == StRepeat) && RepeatEn));
        cnt_clear = !dbsw || !state_is_held(state_q);
    end

    switch_event_gen_tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick_counter (
        .swclock  (swclock),
        .swreset  (swreset),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .terminal (cnt_term),
        .hit      (cnt_hit)
    );

    always_comb begin
        state_d = state_q;
        ev_d    = '0;
        case (state_q)
            StInit: begin
                // A switch already down at reset is parked until it is let go.
                state_d = dbsw ? StWaitRel : StIdle;
            end
            StIdle: begin
                if (dbsw) begin
                    state_d    = StPressed;
                    ev_d.press = 1'b1;
                end
            end
            StPressed: begin
                if (!dbsw) begin
                    state_d            = StIdle;
                    ev_d.release_pulse = 1'b1;
                end else if (cnt_hit) begin
                    state_d         = StRepeat;
                    ev_d.long_press = 1'b1;
                end
            end
            StRepeat: begin
                if (!dbsw) begin
                    state_d            = StIdle;
                    ev_d.release_pulse = 1'b1;
                end else if (cnt_hit) begin
                    ev_d.repeat_pulse = 1'b1;
                end
            end
            StWaitRel: begin
                if (!dbsw) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase
        held_d = state_is_held(state_d);
    end

    always_ff @(posedge swclock) begin
        if (swreset) begin
            state_q <= StInit;
            ev_q    <= '0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ev_q    <= ev_d;
            held_q  <= held_d;
        end
    end

    assign press         = ev_q.press;
    assign release_pulse = ev_q.release_pulse;
    assign long_press    = ev_q.long_press;
    assign repeat_pulse  = ev_q.repeat_pulse;
    assign held          = held_q;
    assign state         = state_q;

`ifndef SYNTHESIS
    a_pulses_exclusive: assert property (@(posedge swclock) $onehot0(ev_q));
    a_held_matches_state: assert property (@(posedge swclock) held_q == state_is_held(state_q));
`endif

endmodule

// File: tb/tb_switch_event_gen.sv
// Bench: two instances (default params, and REPEAT_TICKS = 0) driven by shared stimulus and checked
// every cycle against a hold-time model.
module tb_switch_event_gen;

    localparam int LONG = 8;
    localparam int REP_A = 3;
    localparam int REP_B = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic tick = 1'b0;
    logic db = 1'b0;

    logic       a_press, a_rel, a_long, a_rep, a_held;
    logic [2:0] a_state;
    logic       b_press, b_rel, b_long, b_rep, b_held;
    logic [2:0] b_state;

    switch_event_gen #(
        .LONG_TICKS   (LONG),
        .REPEAT_TICKS (REP_A),
        .CNT_W        (4)
    ) u_dut_a (
        .swclock       (clk),
        .swreset       (rst),
        .swtick        (tick),
        .dbsw          (db),
        .press         (a_press),
        .release_pulse (a_rel),
        .long_press    (a_long),
        .repeat_pulse  (a_rep),
        .held          (a_held),
        .state         (a_state)
    );

    switch_event_gen #(
        .LONG_TICKS   (LONG),
        .REPEAT_TICKS (REP_B),
        .CNT_W        (4)
    ) u_dut_b (
        .swclock       (clk),
        .swreset       (rst),
        .swtick        (tick),
        .dbsw          (db),
        .press         (b_press),
        .release_pulse (b_rel),
        .long_press    (b_long),
        .repeat_pulse  (b_rep),
        .held          (b_held),
        .state         (b_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: tracks whether a press is in progress and how many ticks it has been held.
    int rep_cfg[2] = '{REP_A, REP_B};
    int m_init[2], m_active[2], m_blocked[2], m_ticks[2];
    int e_press[2], e_rel[2], e_long[2], e_rep[2], e_held[2], e_state[2];

    task automatic model_step(input int k);
        e_press[k] = 0; e_rel[k] = 0; e_long[k] = 0; e_rep[k] = 0;
        if (rst) begin
            m_init[k] = 1; m_active[k] = 0; m_blocked[k] = 0; m_ticks[k] = 0;
            e_state[k] = 0; e_held[k] = 0;
        end else if (m_init[k] != 0) begin
            m_init[k] = 0;
            m_blocked[k] = db ? 1 : 0;
            e_state[k] = db ? 4 : 1; e_held[k] = 0;
        end else if (m_blocked[k] != 0) begin
            if (!db) m_blocked[k] = 0;
            e_state[k] = db ? 4 : 1; e_held[k] = 0;
        end else if (m_active[k] == 0) begin
            if (db) begin
                m_active[k] = 1; m_ticks[k] = 0;
                e_press[k] = 1; e_state[k] = 2; e_held[k] = 1;
            end else begin
                e_state[k] = 1; e_held[k] = 0;
            end
        end else if (!db) begin
            m_active[k] = 0;
            e_rel[k] = 1; e_state[k] = 1; e_held[k] = 0;
        end else begin
            if (tick) begin
                m_ticks[k]++;
                if (m_ticks[k] == LONG) e_long[k] = 1;
                else if (m_ticks[k] > LONG && rep_cfg[k] > 0 &&
                         (m_ticks[k] - LONG) % rep_cfg[k] == 0) e_rep[k] = 1;
            end
            e_state[k] = (m_ticks[k] >= LONG) ? 3 : 2;
            e_held[k] = 1;
        end
    endtask

    int c_press, c_rel, c_long, c_rep, c_long_b, c_rep_b, c_unheld_b;

    task automatic clr_counts();
        c_press = 0; c_rel = 0; c_long = 0; c_rep = 0;
        c_long_b = 0; c_rep_b = 0; c_unheld_b = 0;
    endtask

    task automatic step(input logic r, input logic t, input logic d);
        @(negedge clk);
        rst = r; tick = t; db = d;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check("a.press", a_press, e_press[0]);
        check("a.release", a_rel, e_rel[0]);
        check("a.long", a_long, e_long[0]);
        check("a.repeat", a_rep, e_rep[0]);
        check("a.held", a_held, e_held[0]);
        check("a.state", a_state, e_state[0]);
        check("b.press", b_press, e_press[1]);
        check("b.release", b_rel, e_rel[1]);
        check("b.long", b_long, e_long[1]);
        check("b.repeat", b_rep, e_rep[1]);
        check("b.held", b_held, e_held[1]);
        check("b.state", b_state, e_state[1]);
        c_press += int'(a_press); c_rel += int'(a_rel);
        c_long += int'(a_long); c_rep += int'(a_rep);
        c_long_b += int'(b_long); c_rep_b += int'(b_rep);
        if (!b_held) c_unheld_b++;
    endtask

    task automatic do_reset(input logic d);
        step(1'b1, 1'b0, d);
        check("rst.state", a_state, 3'b000);
        check("rst.held", a_held, 1'b0);
        step(1'b1, 1'b0, d);
    endtask

    logic d_cur;

    initial begin
        clr_counts();

        // Short press: no long_press, one press and one release.
        do_reset(1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("s1.idle", a_state, 3'b001);
        clr_counts();
        step(1'b0, 1'b0, 1'b1);
        check("s1.press_now", a_press, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0);
        check("s1.release_now", a_rel, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("s1.long_cnt", 8'(c_long), 8'd0);
        check("s1.final", a_state, 3'b001);

        // Long hold: long after tick 8, repeats after ticks 11 and 14.
        clr_counts();
        step(1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 14; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (i == LONG) check("s2.long_at8", a_long, 1'b1);
            if (i == 11 || i == 14) check("s2.repeat_at", a_rep, 1'b1);
            step(1'b0, 1'b0, 1'b1);
        end
        step(1'b0, 1'b0, 1'b0);
        check("s2.long_cnt", 8'(c_long), 8'd1);
        check("s2.rep_cnt", 8'(c_rep), 8'd2);
        check("s2.rel_cnt", 8'(c_rel), 8'd1);

        // Reset while held: parked in WAIT_REL, no press/release.
        clr_counts();
        do_reset(1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("s3.waitrel", a_state, 3'b100);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("s3.idle", a_state, 3'b001);
        check("s3.press_cnt", 8'(c_press), 8'd0);
        check("s3.rel_cnt", 8'(c_rel), 8'd0);
        step(1'b0, 1'b0, 1'b1);
        check("s3.press_after", a_press, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Release coincides with the 8th tick: release wins.
        clr_counts();
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        check("s4.release", a_rel, 1'b1);
        check("s4.no_long", a_long, 1'b0);
        check("s4.state", a_state, 3'b001);

        // REPEAT_TICKS = 0 instance: one long_press, never a repeat, held throughout.
        clr_counts();
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1);
        check("s5.b_long_cnt", 8'(c_long_b), 8'd1);
        check("s5.b_rep_cnt", 8'(c_rep_b), 8'd0);
        check("s5.b_unheld", 8'(c_unheld_b), 8'd0);
        check("s5.a_rep_cnt", 8'(c_rep), 8'd4);
        step(1'b0, 1'b0, 1'b0);

        // Reset during REPEAT with the switch still down.
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
        check("s6.in_repeat", a_state, 3'b011);
        clr_counts();
        step(1'b1, 1'b0, 1'b1);
        check("s6.init", a_state, 3'b000);
        check("s6.held", a_held, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("s6.waitrel", a_state, 3'b100);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("s6.idle", a_state, 3'b001);
        check("s6.rel_cnt", 8'(c_rel), 8'd0);

        // Randomized stimulus, checked every cycle by the model.
        d_cur = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) d_cur = ~d_cur;
            step(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)), d_cur);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
